// File: rtl/cla_nibble_sequencer.sv
// rtl/cla_nibble_sequencer.sv - nibble-serial operand feeder and result collector around a 4-bit CLA
// Adds two W-bit operands one nibble per clock through an external combinational adder.
module cla_nibble_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           load;
  logic           last;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   sum_reg;
  logic [W-1:0]   sum_next;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           sa;
  logic           sb;
  logic           ovf_reg;
  logic           ovf_next;

  // New sum nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  assign sum_next = W'({add_sum, sum_reg} >> 4);
  assign ovf_next = (sa == sb) && (sum_next[W-1] != sa);
  assign last     = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a_reg <= a;
        b_reg <= b;
        carry <= cin;
        cnt   <= '0;
        sa    <= a[W-1];
        sb    <= b[W-1];
      end else if (state == RUN) begin
        sum_reg <= sum_next;
        carry   <= add_cout;
        a_reg   <= a_reg >> 4;
        b_reg   <= b_reg >> 4;
        cnt     <= cnt + 1'b1;
        if (last) begin
          ovf_reg <= ovf_next;
        end
      end
    end
  end

  // Adder inputs come straight from flops so they settle once per cycle without glitches.
  assign add_a    = (state == RUN) ? a_reg[3:0] : 4'd0;
  assign add_b    = (state == RUN) ? b_reg[3:0] : 4'd0;
  assign add_cin  = (state == RUN) ? carry : 1'b0;

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign sum      = sum_reg;
  assign cout     = carry;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// tb/tb_cla_nibble_sequencer.sv - self-checking bench for cla_nibble_sequencer
`timescale 1ns/1ps
module tb_cla_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  int errors = 0;
  int checks = 0;

  cla_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Stand-in for the combinational 4-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no nibble slicing.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] ms, output logic mco, output logic mo);
    logic [W:0] full;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    ms   = full[W-1:0];
    mco  = full[W];
    mo   = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
  endtask

  // Presents start for one edge; returns at the falling edge after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    start_op(ta, tb_v, tc);
    wait_done(n);
    chk({tag, " latency"}, n, N);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " overflow"}, overflow, eo);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int seen;
    int busy_cnt;
    logic [W-1:0] rs;
    logic rco;
    logic ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset overflow", overflow, 0);
    chk("reset add_a", add_a, 0);
    chk("reset add_b", add_b, 0);
    chk("reset add_cin", add_cin, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      @(negedge clk);
      chk($sformatf("vec%0d done single", i), done, 0);
    end

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rc, rs, rco, ro);
      run_check($sformatf("rand%0d", i), ra, rb, rc, rs, rco, ro);
    end

    // Carry ripples through every nibble cycle.
    start_op(16'hFFFF, 16'h0001, 1'b0);
    chk("chain c1 busy", busy, 1);
    chk("chain c1 add_a", add_a, 4'hF);
    chk("chain c1 add_cin", add_cin, 0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("chain c%0d add_cin", k), add_cin, 1);
    end
    @(negedge clk);
    chk("chain done", done, 1);
    chk("chain sum", sum, 16'h0000);
    chk("chain cout", cout, 1);

    // Start pulsed mid-run must be ignored and not queued.
    start_op(16'h000F, 16'h0001, 1'b0);
    busy_cnt = 1;
    start = 1'b1; a = 16'h1111; b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    chk("ignore busy cycles", busy_cnt, 4);
    chk("ignore sum", sum, 16'h0010);
    @(negedge clk);
    chk("ignore no requeue", busy, 0);

    // Reset in the second run cycle aborts the add.
    start_op(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    #10 rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort idle after", seen, 0);

    // Back-to-back: new start during DONE, no idle gap.
    run_check("b2b first", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    start = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", busy, 1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b done spacing", n, N + 1);
    chk("b2b sum", sum, 16'h0000);
    chk("b2b cout", cout, 1);
    chk("b2b overflow", overflow, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
